// File: rtl/memory_latency_injector.sv
// rtl/memory_latency_injector.sv - single-outstanding SRAM/DRAM latency model with traffic statistics
// Optional per-request jitter of 0..3 cycles: define MEMORY_LATENCY_INJECTOR_JITTER_EN.
module memory_latency_injector #(
    parameter int SIZE_WIDTH          = 16,
    parameter int LATENCY_SRAM_CYCLES = 2,
    parameter int LATENCY_DRAM_CYCLES = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_is_dram,
    input  logic [SIZE_WIDTH-1:0] req_size_bytes,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [SIZE_WIDTH-1:0] resp_size_bytes,
    input  logic [15:0]           cfg_latency_sram,
    input  logic [15:0]           cfg_latency_dram,
    input  logic [9:0]            cfg_dram_hit_milli_pct,
    input  logic                  cfg_use_cfg_latencies,
    output logic [31:0]           total_reqs,
    output logic [31:0]           total_resp,
    output logic [31:0]           sram_reqs,
    output logic [31:0]           dram_reqs,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           busy_cycles,
    output logic                  busy
);

    localparam logic [31:0] PARAM_SRAM_32 = LATENCY_SRAM_CYCLES;
    localparam logic [31:0] PARAM_DRAM_32 = LATENCY_DRAM_CYCLES;
    localparam logic [15:0] PARAM_SRAM    = PARAM_SRAM_32[15:0];
    localparam logic [15:0] PARAM_DRAM    = PARAM_DRAM_32[15:0];

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic [15:0]           lfsr_q;
    logic [15:0]           count_q;
    logic [SIZE_WIDTH-1:0] size_q;

    logic                  accept;
    logic [15:0]           lfsr_dram;
    logic                  dram_hit;
    logic [15:0]           sram_lat;
    logic [15:0]           dram_lat;
    logic [15:0]           base_lat;
    logic [15:0]           lfsr_after;
    logic [15:0]           lfsr_accept;
    logic [15:0]           accept_lat;
`ifdef MEMORY_LATENCY_INJECTOR_JITTER_EN
    logic [16:0]           jitter_sum;
`endif

    assign req_ready = !busy;

    always_comb begin
        accept     = req_valid && !busy;
        lfsr_dram  = lfsr_step(lfsr_q);
        dram_hit   = (cfg_dram_hit_milli_pct >= 10'd1000) ||
                     (lfsr_dram[9:0] < cfg_dram_hit_milli_pct);
        sram_lat   = cfg_use_cfg_latencies ? cfg_latency_sram : PARAM_SRAM;
        dram_lat   = cfg_use_cfg_latencies ? cfg_latency_dram : PARAM_DRAM;
        // a DRAM hit is served at SRAM latency but still counts as DRAM traffic
        base_lat   = (req_is_dram && !dram_hit) ? dram_lat : sram_lat;
        lfsr_after = req_is_dram ? lfsr_dram : lfsr_q;
`ifdef MEMORY_LATENCY_INJECTOR_JITTER_EN
        lfsr_accept = lfsr_step(lfsr_after);
        jitter_sum  = {1'b0, base_lat} + {15'd0, lfsr_accept[1:0]};
        accept_lat  = jitter_sum[16] ? 16'hFFFF : jitter_sum[15:0];
`else
        lfsr_accept = lfsr_after;
        accept_lat  = base_lat;
`endif
    end

    // resp_valid is kept equal to (busy && count_q == 0) so it can be registered
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q          <= 16'hACE1;
            count_q         <= 16'd0;
            size_q          <= '0;
            busy            <= 1'b0;
            resp_valid      <= 1'b0;
            resp_size_bytes <= '0;
            total_reqs      <= 32'd0;
            total_resp      <= 32'd0;
            sram_reqs       <= 32'd0;
            dram_reqs       <= 32'd0;
            stall_cycles    <= 32'd0;
            busy_cycles     <= 32'd0;
        end else if (accept) begin
            lfsr_q     <= lfsr_accept;
            count_q    <= accept_lat;
            size_q     <= req_size_bytes;
            busy       <= 1'b1;
            total_reqs <= total_reqs + 32'd1;
            if (req_is_dram) begin
                dram_reqs <= dram_reqs + 32'd1;
            end else begin
                sram_reqs <= sram_reqs + 32'd1;
            end
            if (accept_lat == 16'd0) begin
                resp_valid      <= 1'b1;
                resp_size_bytes <= req_size_bytes;
            end else begin
                resp_valid <= 1'b0;
            end
        end else if (busy) begin
            busy_cycles <= busy_cycles + 32'd1;
            if (count_q != 16'd0) begin
                count_q      <= count_q - 16'd1;
                stall_cycles <= stall_cycles + 32'd1;
                if (count_q == 16'd1) begin
                    resp_valid      <= 1'b1;
                    resp_size_bytes <= size_q;
                end else begin
                    resp_valid <= 1'b0;
                end
            end else begin
                resp_valid <= 1'b0;
                total_resp <= total_resp + 32'd1;
                busy       <= 1'b0;
            end
        end else begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_latency_injector.sv
// tb/tb_memory_latency_injector.sv - scoreboard bench for memory_latency_injector (default build)
module tb_memory_latency_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_is_dram;
    logic [15:0] req_size_bytes;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_size_bytes;
    logic [15:0] cfg_latency_sram;
    logic [15:0] cfg_latency_dram;
    logic [9:0]  cfg_dram_hit_milli_pct;
    logic        cfg_use_cfg_latencies;
    logic [31:0] total_reqs, total_resp, sram_reqs, dram_reqs, stall_cycles, busy_cycles;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] sb_size[$];
    int          sb_cyc[$];

    logic [15:0] m_lfsr;
    int          exp_stall;
    int          exp_busy;

    memory_latency_injector dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_is_dram(req_is_dram), .req_size_bytes(req_size_bytes),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_size_bytes(resp_size_bytes),
        .cfg_latency_sram(cfg_latency_sram), .cfg_latency_dram(cfg_latency_dram),
        .cfg_dram_hit_milli_pct(cfg_dram_hit_milli_pct), .cfg_use_cfg_latencies(cfg_use_cfg_latencies),
        .total_reqs(total_reqs), .total_resp(total_resp), .sram_reqs(sram_reqs), .dram_reqs(dram_reqs),
        .stall_cycles(stall_cycles), .busy_cycles(busy_cycles), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // response side of the scoreboard
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            checks++;
            if (sb_size.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected cyc=%0d size=%0d", cyc, resp_size_bytes);
            end else begin
                logic [15:0] es;
                int          ec;
                es = sb_size.pop_front();
                ec = sb_cyc.pop_front();
                if (resp_size_bytes !== es) begin
                    failures++;
                    $display("FAIL resp_size got=%0d exp=%0d", resp_size_bytes, es);
                end
                checks++;
                if (cyc !== ec) begin
                    failures++;
                    $display("FAIL resp_timing got_cyc=%0d exp_cyc=%0d", cyc, ec);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_size.delete();
        sb_cyc.delete();
        m_lfsr = 16'hACE1;
        exp_stall = 0;
        exp_busy = 0;
    endtask

    // request side: waits for ready, predicts latency, drives one accept
    task automatic send(input logic is_dram, input logic [15:0] size);
        int n = 0;
        int lat;
        logic [15:0] sl, dl;
        logic hit;
        while (req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_ready_timeout got=%b exp=1", req_ready);
            return;
        end
        sl = cfg_use_cfg_latencies ? cfg_latency_sram : 16'd2;
        dl = cfg_use_cfg_latencies ? cfg_latency_dram : 16'd30;
        hit = 1'b0;
        if (is_dram) begin
            m_lfsr = model_step(m_lfsr);
            hit = (cfg_dram_hit_milli_pct >= 10'd1000) || (m_lfsr[9:0] < cfg_dram_hit_milli_pct);
        end
        lat = (is_dram && !hit) ? int'(dl) : int'(sl);
        exp_stall += lat;
        exp_busy += lat + 1;
        sb_size.push_back(size);
        sb_cyc.push_back(cyc + 1 + lat);
        req_valid = 1'b1;
        req_is_dram = is_dram;
        req_size_bytes = size;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || sb_size.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || sb_size.size() != 0) begin
            failures++;
            $display("FAIL idle_timeout busy=%b pending=%0d exp_pending=0", busy, sb_size.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, req_ready, resp_valid} !== 3'b010) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=010", {busy, req_ready, resp_valid});
        end
        checks++;
        if ({total_reqs, total_resp, sram_reqs, dram_reqs, stall_cycles, busy_cycles} !== 192'd0 ||
            resp_size_bytes !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got_reqs=%0d got_stall=%0d got_size=%0d exp=0",
                     total_reqs, stall_cycles, resp_size_bytes);
        end
    endtask

    task automatic test_param_latency();
        do_reset();
        cfg_use_cfg_latencies = 1'b0;
        cfg_latency_sram = 16'd7;
        cfg_latency_dram = 16'd9;
        cfg_dram_hit_milli_pct = 10'd0;
        send(1'b0, 16'd64);
        wait_idle();
        checks++;
        if (stall_cycles !== 32'd2 || busy_cycles !== 32'd3) begin
            failures++;
            $display("FAIL param_sram_counts stall=%0d busy=%0d exp=2,3", stall_cycles, busy_cycles);
        end
        send(1'b1, 16'd256);
        wait_idle();
        checks++;
        if (stall_cycles !== 32'd32 || dram_reqs !== 32'd1 || total_resp !== 32'd2) begin
            failures++;
            $display("FAIL param_dram_counts stall=%0d dram=%0d resp=%0d exp=32,1,2",
                     stall_cycles, dram_reqs, total_resp);
        end
    endtask

    task automatic test_alternating();
        do_reset();
        cfg_use_cfg_latencies = 1'b1;
        cfg_latency_sram = 16'd5;
        cfg_latency_dram = 16'd10;
        cfg_dram_hit_milli_pct = 10'd0;
        for (int i = 0; i < 8; i++) send(i[0], i[0] ? 16'd128 : 16'd64);
        wait_idle();
        checks++;
        if (total_reqs !== 32'd8 || total_resp !== 32'd8 || sram_reqs !== 32'd4 || dram_reqs !== 32'd4) begin
            failures++;
            $display("FAIL alt_counts reqs=%0d resp=%0d sram=%0d dram=%0d exp=8,8,4,4",
                     total_reqs, total_resp, sram_reqs, dram_reqs);
        end
        checks++;
        if (stall_cycles !== 32'd60 || busy_cycles !== 32'd68) begin
            failures++;
            $display("FAIL alt_cycles stall=%0d busy=%0d exp=60,68", stall_cycles, busy_cycles);
        end
    endtask

    task automatic test_backpressure();
        int last = 0;
        int accepts = 0;
        do_reset();
        cfg_use_cfg_latencies = 1'b1;
        cfg_latency_sram = 16'd5;
        req_is_dram = 1'b0;
        req_size_bytes = 16'd32;
        req_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            checks++;
            if (req_ready !== !busy) begin
                failures++;
                $display("FAIL bp_ready got=%b exp=%b", req_ready, !busy);
            end
            if (req_ready === 1'b1) begin
                if (accepts > 0) begin
                    checks++;
                    if (cyc + 1 - last != 7) begin
                        failures++;
                        $display("FAIL bp_spacing got=%0d exp=7", cyc + 1 - last);
                    end
                end
                last = cyc + 1;
                accepts++;
                sb_size.push_back(16'd32);
                sb_cyc.push_back(cyc + 1 + 5);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle();
        checks++;
        if (total_reqs !== 32'd4 || total_resp !== 32'd4 || stall_cycles !== 32'd20 || busy_cycles !== 32'd24) begin
            failures++;
            $display("FAIL bp_counts reqs=%0d resp=%0d stall=%0d busy=%0d exp=4,4,20,24",
                     total_reqs, total_resp, stall_cycles, busy_cycles);
        end
    endtask

    task automatic test_zero_and_midflight();
        do_reset();
        cfg_use_cfg_latencies = 1'b1;
        cfg_latency_sram = 16'd0;
        cfg_latency_dram = 16'd10;
        cfg_dram_hit_milli_pct = 10'd0;
        send(1'b0, 16'd48);
        wait_idle();
        checks++;
        if (stall_cycles !== 32'd0 || busy_cycles !== 32'd1 || resp_size_bytes !== 16'd48) begin
            failures++;
            $display("FAIL zero_lat stall=%0d busy=%0d size=%0d exp=0,1,48",
                     stall_cycles, busy_cycles, resp_size_bytes);
        end
        send(1'b1, 16'd96);
        cfg_latency_dram = 16'd3;
        send(1'b1, 16'd80);
        wait_idle();
        checks++;
        if (stall_cycles !== 32'd13) begin
            failures++;
            $display("FAIL midflight_stall got=%0d exp=13", stall_cycles);
        end
    endtask

    task automatic test_dram_hit();
        do_reset();
        cfg_use_cfg_latencies = 1'b1;
        cfg_latency_sram = 16'd4;
        cfg_latency_dram = 16'd20;
        cfg_dram_hit_milli_pct = 10'd1000;
        for (int i = 0; i < 4; i++) send(1'b1, 16'(16 * (i + 1)));
        wait_idle();
        checks++;
        if (stall_cycles !== 32'd16 || dram_reqs !== 32'd4 || sram_reqs !== 32'd0) begin
            failures++;
            $display("FAIL hit_all stall=%0d dram=%0d sram=%0d exp=16,4,0", stall_cycles, dram_reqs, sram_reqs);
        end
        cfg_dram_hit_milli_pct = 10'd0;
        send(1'b1, 16'd512);
        send(1'b1, 16'd1024);
        wait_idle();
        checks++;
        if (stall_cycles !== 32'd56) begin
            failures++;
            $display("FAIL hit_none stall=%0d exp=56", stall_cycles);
        end
        cfg_dram_hit_milli_pct = 10'd500;
        for (int i = 0; i < 10; i++) send(1'b1, 16'(i + 1));
        wait_idle();
        checks++;
        if (stall_cycles !== 32'(exp_stall) || busy_cycles !== 32'(exp_busy) || dram_reqs !== 32'd16) begin
            failures++;
            $display("FAIL hit_mixed stall=%0d busy=%0d dram=%0d exp=%0d,%0d,16",
                     stall_cycles, busy_cycles, dram_reqs, exp_stall, exp_busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_use_cfg_latencies = 1'b1;
        cfg_latency_sram = 16'd8;
        send(1'b0, 16'd32);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb_size.delete();
        sb_cyc.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || total_reqs !== 32'd0 ||
            stall_cycles !== 32'd0 || busy_cycles !== 32'd0 || sram_reqs !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b resp=%b reqs=%0d stall=%0d exp=0",
                     busy, resp_valid, total_reqs, stall_cycles);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (total_resp !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_noresp resp=%0d busy=%b exp=0,0", total_resp, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_is_dram = 1'b0;
        req_size_bytes = 16'd0;
        cfg_latency_sram = 16'd0;
        cfg_latency_dram = 16'd0;
        cfg_dram_hit_milli_pct = 10'd0;
        cfg_use_cfg_latencies = 1'b0;
        @(negedge clk);
        test_reset();
        test_param_latency();
        test_alternating();
        test_backpressure();
        test_zero_and_midflight();
        test_dram_hit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_latency_injector.md
Name: memory_latency_injector

Overview:
- Single-outstanding memory-latency model for NPU tile simulation and performance studies.
- Accepts one request at a time, tagged SRAM or DRAM, holds it for a configurable number of cycles, then returns a one-cycle response carrying the request size.
- Keeps 32-bit traffic and stall statistics for the CSR/perf block.

Parameters:
- SIZE_WIDTH, 16: width of the request/response size field, in bytes.
- LATENCY_SRAM_CYCLES, 2: SRAM latency used when cfg_use_cfg_latencies=0.
- LATENCY_DRAM_CYCLES, 30: DRAM latency used when cfg_use_cfg_latencies=0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request strobe.
- req_is_dram  in  1  1=DRAM, 0=SRAM.
- req_size_bytes  in  SIZE_WIDTH  request size.
- req_ready  out  1  equals !busy.
- resp_valid  out  1  one-cycle response pulse.
- resp_size_bytes  out  SIZE_WIDTH  latched size of the completing request.
- cfg_latency_sram  in  16  runtime SRAM latency.
- cfg_latency_dram  in  16  runtime DRAM latency.
- cfg_dram_hit_milli_pct  in  10  DRAM hit rate in 0.1% units, 0..1000.
- cfg_use_cfg_latencies  in  1  1=use cfg_* latencies, 0=use parameters.
- total_reqs, total_resp, sram_reqs, dram_reqs  out  32 each  event counters.
- stall_cycles, busy_cycles  out  32 each  cycle counters.
- busy  out  1  a request is outstanding.

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - On reset, all outputs and counters go to 0, busy=0 and req_ready=1.
  - The LFSR loads 16'hACE1.
  - Reset mid-operation drops the outstanding request; no response is produced.
- Accept:
  - A request is accepted when req_valid && !busy at a clock edge.
  - req_valid while busy is ignored and not counted.
- On accept:
  - Latch req_size_bytes.
  - Select latency L: DRAM or SRAM, from cfg or parameters, per cfg_use_cfg_latencies. Only the low 16 bits of a parameter are used.
  - Load the down-counter with L and set busy=1.
  - total_reqs+1; sram_reqs+1 or dram_reqs+1 by request type.
- Latching: L is fixed at accept. Later cfg changes affect only subsequent requests.
- DRAM hit:
  - On each DRAM accept, advance a 16-bit Fibonacci LFSR with taps 16,14,13,11.
  - The request is a hit if cfg_dram_hit_milli_pct>=1000 or (new LFSR[9:0] < cfg_dram_hit_milli_pct). A hit uses the SRAM latency instead.
  - A hit DRAM request is still counted in dram_reqs.
  - With pct=0 every DRAM request takes the DRAM latency.
- While busy:
  - busy_cycles+1 every cycle.
  - If the counter is >0: decrement it and stall_cycles+1.
  - If the counter is 0: resp_valid=1 for that cycle, resp_size_bytes=latched size, total_resp+1, and busy clears at the next edge.
- Timing: the response is asserted L+1 cycles after the accept edge.
  - L=0 gives a response in the cycle after accept, with no stall.
  - stall_cycles grows by exactly L per request; busy_cycles grows by L+1.
- Back-to-back: busy is still 1 during the resp_valid cycle, so a new request is accepted at the earliest on the edge ending that cycle. Throughput is one request per L+2 cycles.
- Outputs:
  - resp_size_bytes holds its last value when resp_valid=0.
  - All outputs are registered except req_ready.
- Counters wrap modulo 2^32.

Optional Feature:
- Macro: MEMORY_LATENCY_INJECTOR_JITTER_EN.
- When defined:
  - On every accept the LFSR advances; if it already advanced for a DRAM hit decision, it advances once more.
  - LFSR[1:0], i.e. 0..3 extra cycles, is added to L, saturating at 16'hFFFF.
  - stall_cycles counts the actual jittered wait.
- When undefined: latency is exact, the LFSR advances only on DRAM accepts, and no jitter logic is present.

Test Plan:
- Parameter latencies: cfg_use=0, one SRAM request, size 64 -> resp_valid exactly 3 cycles after accept, resp_size_bytes=64, stall_cycles=2, busy_cycles=3.
- Config latencies, alternating traffic: cfg_use=1, sram=5, dram=10, pct=0; 8 alternating requests (SRAM 64B / DRAM 128B) -> total_reqs=total_resp=8, sram_reqs=dram_reqs=4, stall_cycles=60, each wait equals L+1.
- Backpressure: req_valid held high continuously with sram=5 -> req_ready low while busy, one accept per 7 cycles, no extra counts.
- Zero latency and mid-flight cfg change:
  - cfg_latency_sram=0 -> resp_valid the cycle after accept, stall_cycles unchanged.
  - Changing cfg_latency_dram mid-flight -> the in-flight request keeps its latched latency.
- DRAM hit extremes: pct=1000 with DRAM requests -> every request uses the SRAM latency, dram_reqs still counted; pct=0 -> always the DRAM latency.
- Reset mid-request: assert reset while busy with the counter at 5 -> next cycle busy=0, all counters 0, no resp_valid.
